// File: rtl/pc_branch_sequencer.sv
// Drives the PC select code and operand: boot load, sequential fetch, stall hold,
// branch resolution into relative/absolute redirects, then a fixed flush window.
module pc_branch_sequencer #(
  parameter int               WIDTH        = 64,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               FLUSH_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_type,
  input  logic [WIDTH-1:0] br_offset,
  input  logic [WIDTH-1:0] br_target,
  input  logic             reg_zero,
  input  logic [3:0]       flags,
  input  logic [3:0]       cond,
  output logic [1:0]       PS,
  output logic [WIDTH-1:0] pc_in,
  output logic             taken,
  output logic             illegal
);

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_LOAD = 2'b10;
  localparam logic [1:0] PS_REL  = 2'b11;

  localparam logic [2:0] T_B    = 3'd0;
  localparam logic [2:0] T_CBZ  = 3'd1;
  localparam logic [2:0] T_CBNZ = 3'd2;
  localparam logic [2:0] T_BC   = 3'd3;
  localparam logic [2:0] T_BR   = 3'd4;

  localparam int            CW         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH_CYCLES);

  typedef enum logic [1:0] {BOOT, RUN, REDIRECT, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [1:0]       ps_d;
  logic [WIDTH-1:0] pc_in_d;
  logic             ready_d, taken_d, illegal_d;
  logic [CW-1:0]    flush_cnt, flush_d;
  logic [2:0]       lat_type;
  logic [WIDTH-1:0] lat_offset, lat_target;
  logic             lat_load, accept, new_taken, redirect;
  logic [2:0]       sel_type;
  logic [WIDTH-1:0] sel_offset, sel_target;

  // flags = {N, Z, C, V}; odd codes invert the even base test, except 14/15 (always)
  function automatic logic cond_met(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return (cc[3:1] == 3'd7) ? 1'b1 : (base ^ cc[0]);
  endfunction

  always_comb begin
    case (br_type)
      T_B, T_BR: new_taken = 1'b1;
      T_CBZ:     new_taken = reg_zero;
      T_CBNZ:    new_taken = ~reg_zero;
      T_BC:      new_taken = cond_met(cond, flags);
      default:   new_taken = 1'b0;
    endcase
  end

  assign accept = br_ready & br_valid;

  // A redirect issued straight from the accept cycle uses the live request fields.
  assign sel_type   = (state_q == REDIRECT) ? lat_type   : br_type;
  assign sel_offset = (state_q == REDIRECT) ? lat_offset : br_offset;
  assign sel_target = (state_q == REDIRECT) ? lat_target : br_target;

  always_comb begin
    state_d   = state_q;
    ps_d      = PS_HOLD;
    pc_in_d   = pc_in;
    ready_d   = 1'b0;
    taken_d   = 1'b0;
    illegal_d = 1'b0;
    flush_d   = flush_cnt;
    lat_load  = 1'b0;
    redirect  = 1'b0;

    case (state_q)
      BOOT: begin
        ps_d    = PS_LOAD;
        pc_in_d = RESET_VECTOR;
        state_d = RUN;
      end
      RUN: begin
        lat_load = accept;
        if (accept && new_taken) begin
          redirect = 1'b1;
        end else begin
          ps_d      = stall ? PS_HOLD : PS_INC;
          ready_d   = ~stall;
          illegal_d = accept & (br_type > T_BR);
        end
      end
      REDIRECT: redirect = 1'b1;
      FLUSH: begin
        if (flush_cnt == FLUSH_LAST) begin
          state_d = RUN;
          ps_d    = stall ? PS_HOLD : PS_INC;
          ready_d = ~stall;
        end else begin
          flush_d = flush_cnt + CW'(1);
        end
      end
      default: state_d = BOOT;
    endcase

    // Issue the redirect next cycle unless stalled; otherwise park in REDIRECT.
    if (redirect) begin
      if (stall) begin
        state_d = REDIRECT;
        ps_d    = PS_HOLD;
      end else begin
        taken_d = 1'b1;
        flush_d = '0;
        state_d = (FLUSH_CYCLES == 0) ? RUN : FLUSH;
        if (sel_type == T_BR) begin
          ps_d    = PS_LOAD;
          pc_in_d = sel_target;
        end else begin
          ps_d    = PS_REL;
          pc_in_d = sel_offset - WIDTH'(2);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= BOOT;
      PS         <= PS_HOLD;
      pc_in      <= '0;
      br_ready   <= 1'b0;
      taken      <= 1'b0;
      illegal    <= 1'b0;
      flush_cnt  <= '0;
      lat_type   <= '0;
      lat_offset <= '0;
      lat_target <= '0;
    end else begin
      state_q   <= state_d;
      PS        <= ps_d;
      pc_in     <= pc_in_d;
      br_ready  <= ready_d;
      taken     <= taken_d;
      illegal   <= illegal_d;
      flush_cnt <= flush_d;
      if (lat_load) begin
        lat_type   <= br_type;
        lat_offset <= br_offset;
        lat_target <= br_target;
      end
    end
  end

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// Bench for pc_branch_sequencer: table of branch requests against an external PC model,
// plus hand sequences for stalls and reset in the middle of a redirect.
module tb_pc_branch_sequencer;

  localparam logic [63:0] RV = 64'h100;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic        br_ready;
  logic [2:0]  br_type = 3'd0;
  logic [63:0] br_offset = 64'd0;
  logic [63:0] br_target = 64'd0;
  logic        reg_zero = 1'b0;
  logic [3:0]  flags = 4'd0;
  logic [3:0]  cond = 4'd0;
  logic [1:0]  PS;
  logic [63:0] pc_in;
  logic        taken;
  logic        illegal;

  pc_branch_sequencer #(.WIDTH(64), .RESET_VECTOR(RV), .FLUSH_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .stall(stall), .br_valid(br_valid), .br_ready(br_ready),
    .br_type(br_type), .br_offset(br_offset), .br_target(br_target), .reg_zero(reg_zero),
    .flags(flags), .cond(cond), .PS(PS), .pc_in(pc_in), .taken(taken), .illegal(illegal)
  );

  always #5 clock = ~clock;

  // The PC register that PS/pc_in steer.
  logic [63:0] pc = 64'd0;
  always @(posedge clock) begin
    case (PS)
      2'b01:   pc <= pc + 64'd4;
      2'b10:   pc <= pc_in;
      2'b11:   pc <= pc + 64'd4 + (pc_in << 2);
      default: pc <= pc;
    endcase
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " PS"}, 64'(PS), 64'd0);
    chk({tag, " pc_in"}, pc_in, 64'd0);
    chk({tag, " br_ready"}, 64'(br_ready), 64'd0);
    chk({tag, " taken"}, 64'(taken), 64'd0);
    chk({tag, " illegal"}, 64'(illegal), 64'd0);
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (br_ready !== 1'b1 && k < 60) begin
      @(negedge clock);
      k++;
    end
    if (br_ready !== 1'b1) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s ready timeout: got br_ready=%b expected 1", tag, br_ready);
    end
  endtask

  task automatic drive_req(input logic [2:0] t, input logic [63:0] off, input logic [63:0] tgt,
                           input logic rz, input logic [3:0] fl, input logic [3:0] cc);
    br_valid  = 1'b1;
    br_type   = t;
    br_offset = off;
    br_target = tgt;
    reg_zero  = rz;
    flags     = fl;
    cond      = cc;
  endtask

  typedef struct {
    logic [2:0]  t;
    logic [63:0] off;
    logic [63:0] tgt;
    logic        rz;
    logic [3:0]  fl;
    logic [3:0]  cc;
    logic        exp_taken;
    logic        exp_ill;
  } vec_t;

  typedef struct {
    logic        taken;
    logic        ill;
    logic [1:0]  ps;
    logic [63:0] pcin;
    logic [63:0] pc;
  } exp_t;

  vec_t vecs[18];
  exp_t sb[$];

  initial begin
    exp_t        e;
    logic [63:0] a;
    int          pulses;

    // flags = {N,Z,C,V}
    vecs[0]  = '{3'd4, 64'd0,      64'h200,  1'b0, 4'b0000, 4'h0, 1'b1, 1'b0}; // BR
    vecs[1]  = '{3'd0, 64'd4,      64'd0,    1'b0, 4'b0000, 4'h0, 1'b1, 1'b0}; // B +4
    vecs[2]  = '{3'd1, 64'd7,      64'd0,    1'b0, 4'b0000, 4'h0, 1'b0, 1'b0}; // CBZ nz
    vecs[3]  = '{3'd4, 64'd0,      64'h300,  1'b0, 4'b0000, 4'h0, 1'b1, 1'b0}; // BR
    vecs[4]  = '{3'd1, 64'(-3),    64'd0,    1'b1, 4'b0000, 4'h0, 1'b1, 1'b0}; // CBZ z, -3
    vecs[5]  = '{3'd2, 64'd5,      64'd0,    1'b1, 4'b0000, 4'h0, 1'b0, 1'b0}; // CBNZ z
    vecs[6]  = '{3'd2, 64'd8,      64'd0,    1'b0, 4'b0000, 4'h0, 1'b1, 1'b0}; // CBNZ nz
    vecs[7]  = '{3'd3, 64'd1,      64'd0,    1'b0, 4'b1001, 4'hA, 1'b1, 1'b0}; // GE N=V=1
    vecs[8]  = '{3'd3, 64'd6,      64'd0,    1'b0, 4'b1101, 4'hC, 1'b0, 1'b0}; // GT with Z
    vecs[9]  = '{3'd3, 64'd6,      64'd0,    1'b0, 4'b0000, 4'h0, 1'b0, 1'b0}; // EQ Z=0
    vecs[10] = '{3'd3, 64'(-1),    64'd0,    1'b0, 4'b0010, 4'h8, 1'b1, 1'b0}; // HI
    vecs[11] = '{3'd3, 64'd3,      64'd0,    1'b0, 4'b0100, 4'hD, 1'b1, 1'b0}; // LE Z=1
    vecs[12] = '{3'd3, 64'd5,      64'd0,    1'b0, 4'b0000, 4'hE, 1'b1, 1'b0}; // AL
    vecs[13] = '{3'd4, 64'd0,      64'h4000, 1'b0, 4'b0000, 4'h0, 1'b1, 1'b0}; // BR 0x4000
    vecs[14] = '{3'd7, 64'd2,      64'h80,   1'b0, 4'b0000, 4'h0, 1'b0, 1'b1}; // illegal
    vecs[15] = '{3'd5, 64'd2,      64'h80,   1'b0, 4'b0000, 4'h0, 1'b0, 1'b1}; // illegal
    vecs[16] = '{3'd3, 64'd2,      64'd0,    1'b0, 4'b1000, 4'hB, 1'b1, 1'b0}; // LT
    vecs[17] = '{3'd3, 64'd2,      64'd0,    1'b0, 4'b0001, 4'h7, 1'b0, 1'b0}; // VC V=1

    // Reset and boot
    @(negedge clock);
    @(negedge clock);
    chk_reset_outs("reset");
    reset = 1'b0;
    @(negedge clock);
    chk("boot PS", 64'(PS), 64'd2);
    chk("boot pc_in", pc_in, RV);
    chk("boot br_ready", 64'(br_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("fetch PS", 64'(PS), 64'd1);
      chk("fetch pc", pc, RV + 64'(4 * i));
    end

    // Table of branch requests
    for (int i = 0; i < 18; i++) begin
      wait_ready("vec");
      chk("accept PS", 64'(PS), 64'd1);
      a = pc;
      e.taken = vecs[i].exp_taken;
      e.ill   = vecs[i].exp_ill;
      if (!vecs[i].exp_taken) begin
        e.ps = 2'b01; e.pcin = 64'd0; e.pc = a + 64'd4;
      end else if (vecs[i].t == 3'd4) begin
        e.ps = 2'b10; e.pcin = vecs[i].tgt; e.pc = vecs[i].tgt;
      end else begin
        e.ps = 2'b11; e.pcin = vecs[i].off - 64'd2; e.pc = a + (vecs[i].off << 2);
      end
      sb.push_back(e);
      drive_req(vecs[i].t, vecs[i].off, vecs[i].tgt, vecs[i].rz, vecs[i].fl, vecs[i].cc);
      @(negedge clock);
      br_valid = 1'b0;
      e = sb.pop_front();
      chk($sformatf("vec%0d taken", i), 64'(taken), 64'(e.taken));
      chk($sformatf("vec%0d illegal", i), 64'(illegal), 64'(e.ill));
      chk($sformatf("vec%0d PS", i), 64'(PS), 64'(e.ps));
      if (e.taken) begin
        chk($sformatf("vec%0d pc_in", i), pc_in, e.pcin);
        @(negedge clock);
        chk($sformatf("vec%0d target pc", i), pc, e.pc);
        chk($sformatf("vec%0d flush1 PS", i), 64'(PS), 64'd0);
        chk($sformatf("vec%0d flush1 ready", i), 64'(br_ready), 64'd0);
        chk($sformatf("vec%0d taken width", i), 64'(taken), 64'd0);
        @(negedge clock);
        chk($sformatf("vec%0d flush2 PS", i), 64'(PS), 64'd0);
        @(negedge clock);
        chk($sformatf("vec%0d resume PS", i), 64'(PS), 64'd1);
        chk($sformatf("vec%0d resume ready", i), 64'(br_ready), 64'd1);
      end else begin
        chk($sformatf("vec%0d pc", i), pc, e.pc);
      end
    end

    // Stall while running
    wait_ready("stall run");
    stall = 1'b1;
    @(negedge clock);
    chk("run stall PS", 64'(PS), 64'd0);
    chk("run stall ready", 64'(br_ready), 64'd0);
    a = pc;
    @(negedge clock);
    chk("run stall pc hold", pc, a);
    stall = 1'b0;
    @(negedge clock);
    chk("run unstall PS", 64'(PS), 64'd1);
    chk("run unstall ready", 64'(br_ready), 64'd1);

    // Stall holding a pending redirect
    wait_ready("stall redirect");
    a = pc;
    stall = 1'b1;
    drive_req(3'd0, 64'd4, 64'd0, 1'b0, 4'd0, 4'd0);
    @(negedge clock);
    br_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("redir stall PS", 64'(PS), 64'd0);
      chk("redir stall taken", 64'(taken), 64'd0);
      chk("redir stall ready", 64'(br_ready), 64'd0);
      if (k < 2) @(negedge clock);
    end
    stall = 1'b0;
    @(negedge clock);
    chk("redir issue taken", 64'(taken), 64'd1);
    chk("redir issue PS", 64'(PS), 64'd3);
    chk("redir issue pc_in", pc_in, 64'd2);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (k == 0) chk("redir target pc", pc, a + 64'd16);
      if (taken === 1'b1) pulses++;
    end
    chk("redir single pulse", 64'(pulses), 64'd0);

    // Reset while a redirect is pending
    wait_ready("reset redirect");
    stall = 1'b1;
    drive_req(3'd0, 64'd9, 64'd0, 1'b0, 4'd0, 4'd0);
    @(negedge clock);
    br_valid = 1'b0;
    chk("pend PS", 64'(PS), 64'd0);
    reset = 1'b1;
    stall = 1'b0;
    @(negedge clock);
    chk_reset_outs("reset in redirect");
    reset = 1'b0;
    @(negedge clock);
    chk("reboot1 PS", 64'(PS), 64'd2);
    chk("reboot1 pc_in", pc_in, RV);
    @(negedge clock);
    chk("reboot1 run PS", 64'(PS), 64'd1);
    chk("reboot1 no taken", 64'(taken), 64'd0);
    chk("reboot1 pc", pc, RV);

    // Reset during the flush window
    wait_ready("reset flush");
    drive_req(3'd0, 64'd4, 64'd0, 1'b0, 4'd0, 4'd0);
    @(negedge clock);
    br_valid = 1'b0;
    chk("flush-reset issue taken", 64'(taken), 64'd1);
    @(negedge clock);
    chk("flush-reset in flush PS", 64'(PS), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    chk_reset_outs("reset in flush");
    reset = 1'b0;
    @(negedge clock);
    chk("reboot2 PS", 64'(PS), 64'd2);
    @(negedge clock);
    chk("reboot2 run PS", 64'(PS), 64'd1);
    chk("reboot2 no taken", 64'(taken), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/pc_branch_sequencer.md
Name: pc_branch_sequencer

Overview:
Control-side driver for the program counter's select interface: generates the 2-bit PC select code (PS) and the PC operand (pc_in) every cycle. Loads the reset vector after reset, increments during normal fetch, holds on stall, and resolves branch requests from decode (B, CBZ, CBNZ, B.cond, BR) into PC-relative or absolute redirects. After each redirect it holds for a fixed flush window. PS encoding: 00 hold, 01 PC+4, 10 PC<=pc_in, 11 PC<=PC+4+pc_in*4.

Parameters:
WIDTH, 64, PC and operand width
RESET_VECTOR, 0, address loaded into PC after reset
FLUSH_CYCLES, 2, hold cycles after a redirect (0 allowed)

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
stall  input  1  pipeline stall request
br_valid  input  1  branch request valid
br_ready  output  1  sequencer can accept a request this cycle
br_type  input  3  000 B, 001 CBZ, 010 CBNZ, 011 B.cond, 100 BR, others illegal
br_offset  input  WIDTH  signed word offset from the branch instruction's address
br_target  input  WIDTH  absolute byte target (BR)
reg_zero  input  1  tested register == 0 (CBZ/CBNZ)
flags  input  4  NZCV, bit3=N
cond  input  4  B.cond condition code
PS  output  2  PC select
pc_in  output  WIDTH  PC operand
taken  output  1  one-cycle pulse when a redirect is issued
illegal  output  1  one-cycle pulse on acceptance of an illegal br_type

Behaviour:
- Single clock domain, one synchronous active-high reset. All outputs are registered or decoded from registered state only. No combinational path from inputs to PS/pc_in.
- Reset (any state, any cycle): state=BOOT, PS=00, pc_in=0, br_ready=0, taken=0, illegal=0, latched request cleared.
- States: BOOT, RUN, REDIRECT, FLUSH.
- BOOT (first cycle after reset low):
  - PS=10, pc_in=RESET_VECTOR.
  - Next state RUN.
- RUN:
  - stall=1: PS=00, br_ready=0.
  - stall=0: PS=01, br_ready=1.
  - Accept occurs when br_ready & br_valid. The PS=01 is still issued in the accept cycle.
  - On accept, latch the branch fields and evaluate taken from the inputs sampled that cycle.
  - Not-taken or illegal: stay in RUN. illegal pulses next cycle for an illegal br_type.
  - Taken: go to REDIRECT.
- Taken rules:
  - B: always taken.
  - CBZ: taken when reg_zero=1.
  - CBNZ: taken when reg_zero=0.
  - BR: always taken.
  - B.cond codes (Z,C,N,V from flags):
    - 0 EQ Z; 1 NE !Z
    - 2 HS C; 3 LO !C
    - 4 MI N; 5 PL !N
    - 6 VS V; 7 VC !V
    - 8 HI C&!Z; 9 LS !(C&!Z)
    - A GE N==V; B LT N!=V
    - C GT !Z&(N==V); D LE !GT
    - E/F always.
- REDIRECT:
  - stall=1: PS=00, remain in REDIRECT.
  - stall=0, PC-relative types: PS=11, pc_in = br_offset - 2, WIDTH-bit two's complement with wrap. The PC already holds branch+4, so the resulting PC = branch address + 4*br_offset.
  - stall=0, BR: PS=10, pc_in=br_target.
  - Issue cycle: taken=1 for exactly that cycle, br_ready=0. Next state FLUSH, or RUN if FLUSH_CYCLES=0.
- FLUSH:
  - PS=00, br_ready=0, stall ignored.
  - Counts FLUSH_CYCLES cycles, then RUN.
- pc_in holds its last value whenever PS is 00 or 01.
- br_valid while br_ready=0 is ignored, not queued. Upstream holds the request.

Test Plan:
- Reset 2 cycles, release with RESET_VECTOR=0x100 -> BOOT cycle PS=10 pc_in=0x100. Then PS=01 each cycle; PC model reads 0x104, 0x108, 0x10C.
- PC=0x200, accept B with br_offset=4 -> accept cycle PS=01 (PC 0x204). REDIRECT PS=11 pc_in=2, taken=1, PC=0x210. Two cycles PS=00, br_ready=0, then PS=01.
- Accept CBZ with reg_zero=0 -> no taken pulse, PS=01 continues. Repeat with reg_zero=1, br_offset=-3 from PC=0x300 -> pc_in=0xFFFF_FFFF_FFFF_FFFB, PC=0x2F4.
- B.cond GE with flags N=1 V=1 -> taken. B.cond GT with N=1 V=1 Z=1 -> not taken. BR br_target=0x4000 -> PS=10 pc_in=0x4000.
- stall=1 during RUN and during REDIRECT -> PS=00, br_ready=0 and redirect delayed. After stall drops, the redirect issues once with taken=1 for one cycle only.
- reset asserted in FLUSH and in REDIRECT -> next cycle all outputs at reset values, pending redirect discarded, BOOT follows. br_type=111 -> illegal pulse, no redirect.
